// File: rtl/mux_4way_arbiter.sv
// mux_4way_arbiter: round-robin merger of four valid/ready word channels
// into one registered output stage. A channel that wins a multi-beat
// packet keeps the output until the packet's last beat. out_sel tags each
// word with its source (a=00, b=01, c=10, d=11) so a demux can route it back.
module mux_4way_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic             valid_a,
    input  logic             valid_b,
    input  logic             valid_c,
    input  logic             valid_d,
    input  logic             last_a,
    input  logic             last_b,
    input  logic             last_c,
    input  logic             last_d,
    output logic             ready_a,
    output logic             ready_b,
    output logic             ready_c,
    output logic             ready_d,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_last,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    state_t           state;
    logic [1:0]       owner;
    logic [1:0]       ptr;

    logic [3:0]       valid_vec;
    logic [3:0]       last_vec;
    logic [WIDTH-1:0] data_vec [4];

    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic             load_en;
    logic             accept;
    logic [3:0]       ready_vec;

    assign valid_vec   = {valid_d, valid_c, valid_b, valid_a};
    assign last_vec    = {last_d, last_c, last_b, last_a};
    assign data_vec[0] = in_a;
    assign data_vec[1] = in_b;
    assign data_vec[2] = in_c;
    assign data_vec[3] = in_d;

    // The output stage can take a word when it is empty or being drained.
    assign load_en = !out_valid || out_ready;
    assign accept  = load_en && grant_any;

    // Pick the granted channel: the packet owner while locked, otherwise the
    // first valid channel after the previous packet winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        if (state == LOCK) begin
            if (valid_vec[owner]) begin
                grant_any = 1'b1;
                grant_idx = owner;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand = ptr + 2'(k);
                if (!grant_any && valid_vec[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Only the granted channel sees ready, and only when its word can load.
    always_comb begin
        ready_vec = 4'b0000;
        if (rst_n && accept) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign ready_a = ready_vec[0];
    assign ready_b = ready_vec[1];
    assign ready_c = ready_vec[2];
    assign ready_d = ready_vec[3];

    // Output register and packet-lock state machine, updated together so a
    // consumed word is replaced on the same edge without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= 2'b00;
            state     <= ARB;
            owner     <= 2'b00;
            ptr       <= 2'b11;
        end else begin
            if (load_en) begin
                if (grant_any) begin
                    out       <= data_vec[grant_idx];
                    out_last  <= last_vec[grant_idx];
                    out_sel   <= grant_idx;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            case (state)
                ARB: begin
                    if (accept) begin
                        if (last_vec[grant_idx]) begin
                            ptr <= grant_idx;
                        end else begin
                            owner <= grant_idx;
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (accept && last_vec[owner]) begin
                        ptr   <= owner;
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4way_arbiter.sv
// tb_mux_4way_arbiter: directed test of the 4-way packet merger. Per-channel
// sender queues drive the inputs, a packet-level model predicts every output
// each cycle, and literal checks pin the behaviour of the directed scenarios.
module tb_mux_4way_arbiter;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0, valid_d = 1'b0;
    logic        last_a = 1'b0, last_b = 1'b0, last_c = 1'b0, last_d = 1'b0;
    logic        ready_a, ready_b, ready_c, ready_d;
    logic [15:0] out;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];
    beat_t qd[$];

    mux_4way_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .valid_a   (valid_a),
        .valid_b   (valid_b),
        .valid_c   (valid_c),
        .valid_d   (valid_d),
        .last_a    (last_a),
        .last_b    (last_b),
        .last_c    (last_c),
        .last_d    (last_d),
        .ready_a   (ready_a),
        .ready_b   (ready_b),
        .ready_c   (ready_c),
        .ready_d   (ready_d),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    wire [3:0] vld = {valid_d, valid_c, valid_b, valid_a};
    wire [3:0] rdy = {ready_d, ready_c, ready_b, ready_a};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive each channel from the head of its sender queue.
    task automatic refresh();
        valid_a = qa.size() != 0;
        in_a    = valid_a ? qa[0].data : 16'h0;
        last_a  = valid_a ? qa[0].last : 1'b0;
        valid_b = qb.size() != 0;
        in_b    = valid_b ? qb[0].data : 16'h0;
        last_b  = valid_b ? qb[0].last : 1'b0;
        valid_c = qc.size() != 0;
        in_c    = valid_c ? qc[0].data : 16'h0;
        last_c  = valid_c ? qc[0].last : 1'b0;
        valid_d = qd.size() != 0;
        in_d    = valid_d ? qd[0].data : 16'h0;
        last_d  = valid_d ? qd[0].last : 1'b0;
    endtask

    task automatic applyStimulus(input int ch, input logic [15:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        case (ch)
            0: qa.push_back(b);
            1: qb.push_back(b);
            2: qc.push_back(b);
            default: qd.push_back(b);
        endcase
        refresh();
    endtask

    // Senders retire a word once it was accepted at a rising edge.
    always @(posedge clk) begin
        logic [3:0] acc;
        acc = vld & rdy;
        #1;
        if (acc[0]) void'(qa.pop_front());
        if (acc[1]) void'(qb.pop_front());
        if (acc[2]) void'(qc.pop_front());
        if (acc[3]) void'(qd.pop_front());
        refresh();
    end

    // ---------------- packet-level reference model ----------------
    logic [15:0] m_out    = 16'h0;
    logic        m_valid  = 1'b0;
    logic        m_last   = 1'b0;
    logic [1:0]  m_sel    = 2'b00;
    int          m_winner = 3;
    bit          m_locked = 1'b0;
    int          m_owner  = 0;

    function automatic logic [15:0] data_of(input int g);
        case (g)
            0: return in_a;
            1: return in_b;
            2: return in_c;
            default: return in_d;
        endcase
    endfunction

    function automatic logic last_of(input int g);
        case (g)
            0: return last_a;
            1: return last_b;
            2: return last_c;
            default: return last_d;
        endcase
    endfunction

    // Which channel the rules allow this cycle, -1 if none.
    function automatic int pick(input logic [3:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_winner + k) % 4]) return (m_winner + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = pick(vld);
        if (rst_n && (!m_valid || out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_out = 16'h0; m_valid = 1'b0; m_last = 1'b0; m_sel = 2'b00;
            m_winner = 3; m_locked = 1'b0; m_owner = 0;
        end else begin
            g = pick(vld);
            if (!m_valid || out_ready) begin
                if (g >= 0) begin
                    m_out   = data_of(g);
                    m_last  = last_of(g);
                    m_sel   = 2'(g);
                    m_valid = 1'b1;
                    if (last_of(g)) begin
                        m_winner = g;
                        m_locked = 1'b0;
                    end else begin
                        m_owner  = g;
                        m_locked = 1'b1;
                    end
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        checkOutput("model_ready", {28'h0, rdy}, {28'h0, exp_ready()});
        checkOutput("model_out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        checkOutput("model_out", {16'h0, out}, {16'h0, m_out});
        checkOutput("model_out_last", {31'h0, out_last}, {31'h0, m_last});
        checkOutput("model_out_sel", {30'h0, out_sel}, {30'h0, m_sel});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0 &&
                qd.size() == 0 && !m_valid) return;
        end
        n_checks++;
        n_fail++;
        $display("[TB] FAIL drain_timeout: queues or output still busy after 60 cycles");
    endtask

    initial begin
        logic [15:0] cexp [3];
        cexp[0] = 16'h1111;
        cexp[1] = 16'h2222;
        cexp[2] = 16'h3333;

        // Reset with all channels valid and the sink ready.
        $display("[TB] reset and round robin");
        out_ready = 1'b1;
        rst_n     = 1'b0;
        applyStimulus(0, 16'h000A, 1'b1);
        applyStimulus(1, 16'h000B, 1'b1);
        applyStimulus(2, 16'h000C, 1'b1);
        applyStimulus(3, 16'h000D, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_out", {16'h0, out}, 32'h0);
        checkOutput("rst_out_sel", {30'h0, out_sel}, 32'h0);
        checkOutput("rst_out_last", {31'h0, out_last}, 32'h0);
        checkOutput("rst_ready", {28'h0, rdy}, 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rr_first_ready", {28'h0, rdy}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rr_out", {16'h0, out}, 32'h000A + 32'(i));
            checkOutput("rr_sel", {30'h0, out_sel}, 32'(i));
            checkOutput("rr_valid", {31'h0, out_valid}, 32'h1);
        end
        @(negedge clk);
        checkOutput("rr_valid_drop", {31'h0, out_valid}, 32'h0);

        // Channel c holds the output for its 3-beat packet while a waits.
        $display("[TB] packet lock");
        tick();
        applyStimulus(2, 16'h1111, 1'b0);
        applyStimulus(2, 16'h2222, 1'b0);
        applyStimulus(2, 16'h3333, 1'b1);
        @(negedge clk);
        checkOutput("lock_ready_c", {31'h0, ready_c}, 32'h1);
        tick();
        applyStimulus(0, 16'h0A01, 1'b1);
        applyStimulus(0, 16'h0A02, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("lock_out", {16'h0, out}, {16'h0, cexp[i]});
            checkOutput("lock_sel", {30'h0, out_sel}, 32'h2);
            if (i < 2) checkOutput("lock_ready_a", {31'h0, ready_a}, 32'h0);
        end
        checkOutput("lock_last", {31'h0, out_last}, 32'h1);
        @(negedge clk);
        checkOutput("lock_after_sel", {30'h0, out_sel}, 32'h0);
        checkOutput("lock_after_out", {16'h0, out}, 32'h0A01);
        drain();

        // Output stalls with 00AA held, then refills on the consuming edge.
        $display("[TB] backpressure");
        tick();
        applyStimulus(0, 16'h00AA, 1'b1);
        applyStimulus(0, 16'h00AB, 1'b1);
        @(negedge clk);
        checkOutput("bp_ready_a", {31'h0, ready_a}, 32'h1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_out", {16'h0, out}, 32'h00AA);
            checkOutput("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            checkOutput("bp_hold_ready", {28'h0, rdy}, 32'h0);
        end
        #1;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready_a", {31'h0, ready_a}, 32'h1);
        @(negedge clk);
        checkOutput("bp_next_out", {16'h0, out}, 32'h00AB);
        checkOutput("bp_next_valid", {31'h0, out_valid}, 32'h1);
        drain();

        // d wins once so that a is next in line, then a and b compete.
        $display("[TB] fairness");
        tick();
        applyStimulus(3, 16'h00DD, 1'b1);
        drain();
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 16'h0A10 + 16'(i), 1'b1);
            applyStimulus(1, 16'h0B10 + 16'(i), 1'b1);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fair_sel", {30'h0, out_sel}, 32'(i % 2));
        end
        drain();

        // Reset lands after the first beat of d's packet while b waits.
        $display("[TB] reset mid-packet");
        tick();
        applyStimulus(3, 16'hD001, 1'b0);
        applyStimulus(3, 16'hD002, 1'b0);
        applyStimulus(3, 16'hD003, 1'b1);
        @(negedge clk);
        checkOutput("mid_ready_d", {31'h0, ready_d}, 32'h1);
        tick();
        applyStimulus(1, 16'h0B99, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("mid_rst_out", {16'h0, out}, 32'h0);
        checkOutput("mid_rst_ready", {28'h0, rdy}, 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_ready_b", {31'h0, ready_b}, 32'h1);
        checkOutput("mid_ready_d_blocked", {31'h0, ready_d}, 32'h0);
        @(negedge clk);
        checkOutput("mid_first_sel", {30'h0, out_sel}, 32'h1);
        checkOutput("mid_first_out", {16'h0, out}, 32'h0B99);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
